// File: rtl/rc4_ksa_param.sv
// RC4 key-scheduling engine driving an external synchronous S-RAM.
// Optionally fills S[i]=i, then runs the i/j swap loop with a 6-cycle read-read-write-write iteration.
module rc4_ksa_param #(
  parameter  int KEY_BYTES = 3,
  parameter  int ADDR_W    = 8,
  parameter  int INIT_EN   = 1,
  localparam int KEY_W     = 8 * KEY_BYTES,
  localparam int KL_W      = $clog2(KEY_BYTES) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [KEY_W-1:0]  secret_key,
  input  logic [KL_W-1:0]   key_len,
  input  logic [7:0]        read_data,
  output logic [ADDR_W-1:0] address_out,
  output logic [7:0]        data,
  output logic              write_en,
  output logic              busy,
  output logic              finished
);

  localparam int KI_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KL_W-1:0] KEY_BYTES_L = KL_W'(KEY_BYTES);

  typedef enum logic [3:0] {
    IDLE, INIT, RD_I, LAT_I, RD_J, LAT_J, WR_I, WR_J, DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   i_reg, j_reg;
  logic [KI_W-1:0]     kidx_reg;
  logic [KEY_W-1:0]    key_reg;
  logic [KL_W-1:0]     klen_reg;
  logic [7:0]          si_reg, sj_reg;
  logic                finished_reg;

  logic [7:0]          key_bytes [2**KI_W];
  logic [7:0]          key_byte;
  logic [KL_W-1:0]     klen_eff;
  logic [KL_W-1:0]     klen_m1;
  logic [ADDR_W-1:0]   j_sum;

  // Key byte 0 is the most significant byte; unused index slots read as zero.
  genvar gi;
  generate
    for (gi = 0; gi < 2**KI_W; gi++) begin : g_key
      if (gi < KEY_BYTES) begin : g_used
        assign key_bytes[gi] = key_reg[KEY_W-1-8*gi -: 8];
      end else begin : g_pad
        assign key_bytes[gi] = 8'h00;
      end
    end
  endgenerate

  assign key_byte = key_bytes[kidx_reg];
  assign klen_eff = (key_len == '0 || key_len > KEY_BYTES_L) ? KEY_BYTES_L : key_len;
  assign klen_m1  = klen_reg - KL_W'(1);
  assign j_sum    = j_reg + read_data[ADDR_W-1:0] + key_byte[ADDR_W-1:0];
  assign finished = finished_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      i_reg        <= '0;
      j_reg        <= '0;
      kidx_reg     <= '0;
      key_reg      <= '0;
      klen_reg     <= '0;
      si_reg       <= '0;
      sj_reg       <= '0;
      finished_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            key_reg      <= secret_key;
            klen_reg     <= klen_eff;
            i_reg        <= '0;
            j_reg        <= '0;
            kidx_reg     <= '0;
            finished_reg <= 1'b0;
          end else if (state_reg == DONE) begin
            finished_reg <= 1'b1;
          end
        end
        INIT:  i_reg <= i_reg + 1'b1;
        LAT_I: begin
          si_reg <= read_data;
          j_reg  <= j_sum;
        end
        LAT_J: sj_reg <= read_data;
        WR_J: begin
          i_reg    <= i_reg + 1'b1;
          kidx_reg <= (KL_W'(kidx_reg) == klen_m1) ? '0 : kidx_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (start) state_next = (INIT_EN != 0) ? INIT : RD_I;
      INIT:       if (i_reg == '1) state_next = RD_I;
      RD_I:       state_next = LAT_I;
      LAT_I:      state_next = RD_J;
      RD_J:       state_next = LAT_J;
      LAT_J:      state_next = WR_I;
      WR_I:       state_next = WR_J;
      WR_J:       state_next = (i_reg == '1) ? DONE : RD_I;
      default:    state_next = IDLE;
    endcase
  end

  // When i==j both writes land on one address; the WR_J value simply wins.
  always_comb begin
    address_out = '0;
    data        = '0;
    write_en    = 1'b0;
    busy        = 1'b1;
    case (state_reg)
      INIT: begin
        address_out = i_reg;
        data        = 8'(i_reg);
        write_en    = 1'b1;
      end
      RD_I, LAT_I: address_out = i_reg;
      RD_J, LAT_J: address_out = j_reg;
      WR_I: begin
        address_out = i_reg;
        data        = sj_reg;
        write_en    = 1'b1;
      end
      WR_J: begin
        address_out = j_reg;
        data        = si_reg;
        write_en    = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_rc4_ksa_param.sv
// Directed bench: three engines (4-entry with fill, 256-entry with fill, 4-entry preloaded),
// each attached to a behavioural synchronous RAM.
module tb_rc4_ksa_param;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // engine a: ADDR_W=2, INIT_EN=1
  logic        rst_a = 1'b0, start_a = 1'b0;
  logic [23:0] key_a = '0;
  logic [2:0]  klen_a = '0;
  logic [7:0]  rd_a, data_a;
  logic [1:0]  addr_a;
  logic        we_a, busy_a, fin_a;
  logic [7:0]  mem_a [4];

  // engine b: ADDR_W=8, INIT_EN=1
  logic        rst_b = 1'b0, start_b = 1'b0, clr_b = 1'b0;
  logic [23:0] key_b = '0;
  logic [2:0]  klen_b = '0;
  logic [7:0]  rd_b, data_b, addr_b;
  logic        we_b, busy_b, fin_b;
  logic [7:0]  mem_b [256];
  logic [7:0]  exp_b [256];
  int          wcnt_b;
  logic        init_bad_b;

  // engine c: ADDR_W=2, INIT_EN=0
  logic        rst_c = 1'b0, start_c = 1'b0, preload_c = 1'b0;
  logic [23:0] key_c = '0;
  logic [2:0]  klen_c = '0;
  logic [7:0]  rd_c, data_c;
  logic [1:0]  addr_c;
  logic        we_c, busy_c, fin_c;
  logic [7:0]  mem_c [4];

  rc4_ksa_param #(.KEY_BYTES(3), .ADDR_W(2), .INIT_EN(1)) dut_a (
    .clk(clk), .reset_n(rst_a), .start(start_a), .secret_key(key_a), .key_len(klen_a),
    .read_data(rd_a), .address_out(addr_a), .data(data_a), .write_en(we_a),
    .busy(busy_a), .finished(fin_a));

  rc4_ksa_param #(.KEY_BYTES(3), .ADDR_W(8), .INIT_EN(1)) dut_b (
    .clk(clk), .reset_n(rst_b), .start(start_b), .secret_key(key_b), .key_len(klen_b),
    .read_data(rd_b), .address_out(addr_b), .data(data_b), .write_en(we_b),
    .busy(busy_b), .finished(fin_b));

  rc4_ksa_param #(.KEY_BYTES(3), .ADDR_W(2), .INIT_EN(0)) dut_c (
    .clk(clk), .reset_n(rst_c), .start(start_c), .secret_key(key_c), .key_len(klen_c),
    .read_data(rd_c), .address_out(addr_c), .data(data_c), .write_en(we_c),
    .busy(busy_c), .finished(fin_c));

  always @(posedge clk) begin
    if (we_a) mem_a[addr_a] <= data_a;
    rd_a <= mem_a[addr_a];
  end

  // Also tallies writes: the first 256 must be the ascending identity fill.
  always @(posedge clk) begin
    if (we_b) mem_b[addr_b] <= data_b;
    rd_b <= mem_b[addr_b];
    if (clr_b) begin
      wcnt_b     <= 0;
      init_bad_b <= 1'b0;
    end else if (we_b) begin
      if (wcnt_b < 256 && (addr_b != wcnt_b[7:0] || data_b != wcnt_b[7:0])) init_bad_b <= 1'b1;
      wcnt_b <= wcnt_b + 1;
    end
  end

  always @(posedge clk) begin
    if (preload_c) begin
      for (int k = 0; k < 4; k++) mem_c[k] <= 8'(k);
    end else if (we_c) begin
      mem_c[addr_c] <= data_c;
    end
    rd_c <= mem_c[addr_c];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic fin_of(input int d);
    case (d)
      0:       return fin_a;
      1:       return fin_b;
      default: return fin_c;
    endcase
  endfunction

  task automatic do_start(input int d, input logic [23:0] key, input logic [2:0] len);
    @(negedge clk);
    case (d)
      0:       begin key_a = key; klen_a = len; start_a = 1'b1; end
      1:       begin key_b = key; klen_b = len; start_b = 1'b1; end
      default: begin key_c = key; klen_c = len; start_c = 1'b1; end
    endcase
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  // Counts edges after the start edge until finished is seen high.
  task automatic wait_fin(input int d, input int c0, output int cyc);
    cyc = c0;
    while (fin_of(d) !== 1'b1 && cyc < 4000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic chk_ram4(input int d, input string tag, input logic [31:0] expv);
    logic [7:0] obs;
    for (int k = 0; k < 4; k++) begin
      obs = (d == 0) ? mem_a[k] : mem_c[k];
      chk($sformatf("%s[%0d]", tag, k), 32'(obs), 32'(expv[31-8*k -: 8]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int nbad;
    logic [7:0] s [256];
    logic [7:0] kb [3];
    logic [7:0] t;
    logic [7:0] jj;

    // reference KSA for key 00 02 49
    kb[0] = 8'h00; kb[1] = 8'h02; kb[2] = 8'h49;
    for (int k = 0; k < 256; k++) s[k] = 8'(k);
    jj = 8'h00;
    for (int k = 0; k < 256; k++) begin
      jj = jj + s[k] + kb[k % 3];
      t = s[k]; s[k] = s[jj]; s[jj] = t;
    end
    for (int k = 0; k < 256; k++) exp_b[k] = s[k];

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({busy_a, fin_a, we_a, addr_a, data_a}), 32'd0);
    chk("reset_outputs_c", 32'({busy_c, fin_c, we_c, addr_c, data_c}), 32'd0);
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

    // full key 01 02 03
    do_start(0, 24'h010203, 3'd3);
    chk("busy_after_start", 32'(busy_a), 32'd1);
    wait_fin(0, 0, cyc);
    chk("latency_len3", cyc, 29);
    chk("done_outputs", 32'({busy_a, we_a, addr_a, data_a}), 32'd0);
    chk_ram4(0, "ram_len3", 32'h02000103);

    // key byte 0x01 every iteration: j = 1,2,3,0
    do_start(0, 24'h010203, 3'd1);
    chk("fin_cleared", 32'(fin_a), 32'd0);
    wait_fin(0, 0, cyc);
    chk("latency_len1", cyc, 29);
    chk_ram4(0, "ram_len1", 32'h00020301);

    do_start(0, 24'h010203, 3'd0);
    wait_fin(0, 0, cyc);
    chk_ram4(0, "ram_len0", 32'h02000103);

    do_start(0, 24'h010203, 3'd5);
    wait_fin(0, 0, cyc);
    chk_ram4(0, "ram_len5", 32'h02000103);

    // second start mid-shuffle must be ignored
    do_start(0, 24'h010203, 3'd3);
    cyc = 0;
    repeat (10) begin @(posedge clk); #1; cyc++; end
    @(negedge clk);
    key_a = 24'hFFFFFF; klen_a = 3'd1; start_a = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    start_a = 1'b0;
    wait_fin(0, cyc, cyc);
    chk("latency_restart_ignored", cyc, 29);
    chk_ram4(0, "ram_restart_ignored", 32'h02000103);

    // reset during iteration 2, with start also high (must be ignored)
    do_start(0, 24'h010203, 3'd3);
    repeat (16) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0; start_a = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_outputs", 32'({busy_a, fin_a, we_a, addr_a, data_a}), 32'd0);
    @(negedge clk);
    rst_a = 1'b1; start_a = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_idle", 32'({busy_a, we_a}), 32'd0);
    do_start(0, 24'h010203, 3'd3);
    wait_fin(0, 0, cyc);
    chk("latency_after_abort", cyc, 29);
    chk_ram4(0, "ram_after_abort", 32'h02000103);

    // 256-entry run against the reference model
    @(negedge clk); clr_b = 1'b1;
    @(posedge clk); #1; clr_b = 1'b0;
    do_start(1, 24'h000249, 3'd3);
    wait_fin(1, 0, cyc);
    chk("latency_n256", cyc, 1793);
    nbad = 0;
    for (int k = 0; k < 256; k++) begin
      if (mem_b[k] !== exp_b[k]) nbad++;
    end
    chk("ram_n256_mismatches", nbad, 0);
    chk("ram_n256_entry0", 32'(mem_b[0]), 32'(exp_b[0]));
    chk("write_count_n256", wcnt_b, 768);
    chk("init_writes_n256", 32'(init_bad_b), 32'd0);

    // shuffle-only engine over a preloaded identity RAM
    @(negedge clk); preload_c = 1'b1;
    @(posedge clk); #1; preload_c = 1'b0;
    do_start(2, 24'h010203, 3'd3);
    wait_fin(2, 0, cyc);
    chk("latency_noinit", cyc, 25);
    chk_ram4(2, "ram_noinit", 32'h02000103);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
